// File: rtl/demux4_reg.sv
// demux4_reg: registered 1-to-4 demux with valid/ready per channel; DEMUX4_STALL_CNT_EN adds stall_count
module demux4_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data_0,
  output logic [WIDTH-1:0] out_data_1,
  output logic [WIDTH-1:0] out_data_2,
  output logic [WIDTH-1:0] out_data_3
`ifdef DEMUX4_STALL_CNT_EN
  ,
  output logic [7:0]       stall_count
`endif
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} st_t;
  st_t st [4];
  st_t st_nx [4];
  logic [WIDTH-1:0] d [4];
  logic [3:0] load;
  logic accept;
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign accept = in_valid & in_ready;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      load[i] = accept && in_sel == 2'(i);
      st_nx[i] = load[i] ? FULL : (st[i] == FULL && out_ready[i]) ? EMPTY : st[i];
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        st[i] <= EMPTY;
        d[i] <= '0;
      end else begin
        st[i] <= st_nx[i];
        if (load[i]) d[i] <= in_data;
      end
    end
  end
  for (genvar n = 0; n < 4; n++) begin : g_ch
    assign out_valid[n] = st[n] == FULL;
  end
  assign out_data_0 = d[0];
  assign out_data_1 = d[1];
  assign out_data_2 = d[2];
  assign out_data_3 = d[3];
`ifdef DEMUX4_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_count <= '0;
    else if (in_valid && !in_ready && stall_count != 8'hFF) stall_count <= stall_count + 8'd1;
  end
`endif
endmodule
